// File: rtl/sum_block_engine_if.sv
// ---------------------------------------------------------------------------
// sum_block_engine_if
//   Bus between the sum_block_engine and a single-port synchronous RAM.
//
//   mem_address      : word address for the current read or write
//   mem_read_enable  : read request; the RAM registers the word on this edge
//   mem_write_enable : write strobe; the RAM stores mem_data_in on this edge
//   mem_data_in      : write data towards the RAM
//   mem_data_out     : read data from the RAM, valid the cycle after a read
//
//   master : the engine side
//   slave  : the RAM side
// ---------------------------------------------------------------------------
interface sum_block_engine_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read_enable;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      output mem_address,
      output mem_read_enable,
      output mem_write_enable,
      output mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  mem_address,
      input  mem_read_enable,
      input  mem_write_enable,
      input  mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/sum_block_engine.sv
// ---------------------------------------------------------------------------
// sum_block_engine
//   Walks NUM_GROUPS groups of GROUP_LEN consecutive RAM words, writes each
//   group's sum to the word that follows the group, then writes the grand
//   total of all group sums to TOTAL_ADDR. A single-cycle ready pulse marks
//   completion, after which the engine idles until the next reset.
//   All arithmetic wraps modulo 2^DATA_W.
//
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; low aborts and clears everything
//   ready : high for exactly one cycle after the final write
//   mem   : RAM bus (master side), see sum_block_engine_if
// ---------------------------------------------------------------------------
module sum_block_engine #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 5,
   parameter int GROUP_LEN  = 4,
   parameter int NUM_GROUPS = 5,
   parameter int TOTAL_ADDR = 31
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ready,
   sum_block_engine_if.master   mem
);

   localparam int WORD_W  = (GROUP_LEN  > 1) ? $clog2(GROUP_LEN)  : 1;
   localparam int GROUP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_BLK,
      S_WR_TOT,
      S_FIN,
      S_HALT
   } state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  group_sum;
   logic [DATA_W-1:0]  total_sum;
   logic [WORD_W-1:0]  word_idx;
   logic [GROUP_W-1:0] group_idx;

   logic               last_word;
   logic               last_group;
   logic [ADDR_W-1:0]  group_base;

   assign last_word  = (word_idx  == WORD_W'(GROUP_LEN - 1));
   assign last_group = (group_idx == GROUP_W'(NUM_GROUPS - 1));
   // Groups sit back to back with one result word each, hence the stride.
   assign group_base = ADDR_W'(int'(group_idx) * (GROUP_LEN + 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         group_sum <= '0;
         total_sum <= '0;
         word_idx  <= '0;
         group_idx <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_RD_WAIT: begin
               // Read data is valid only in the cycle after the request.
               group_sum <= group_sum + mem.mem_data_out;
               if (!last_word) word_idx <= word_idx + WORD_W'(1);
            end
            S_WR_BLK: begin
               total_sum <= total_sum + group_sum;
               group_sum <= '0;
               word_idx  <= '0;
               if (!last_group) group_idx <= group_idx + GROUP_W'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output and the next state get a default before the case, so
   // no path through this block can leave a signal unassigned (no latches).
   always_comb begin
      state_nxt            = state;
      ready                = 1'b0;
      mem.mem_read_enable  = 1'b0;
      mem.mem_write_enable = 1'b0;
      mem.mem_address      = '0;
      mem.mem_data_in      = '0;
      case (state)
         S_IDLE:    state_nxt = S_RD_REQ;
         S_RD_REQ: begin
            mem.mem_read_enable = 1'b1;
            mem.mem_address     = group_base + ADDR_W'(word_idx);
            state_nxt           = S_RD_WAIT;
         end
         S_RD_WAIT: state_nxt = last_word ? S_WR_BLK : S_RD_REQ;
         S_WR_BLK: begin
            mem.mem_write_enable = 1'b1;
            mem.mem_address      = group_base + ADDR_W'(GROUP_LEN);
            mem.mem_data_in      = group_sum;
            state_nxt            = last_group ? S_WR_TOT : S_RD_REQ;
         end
         S_WR_TOT: begin
            mem.mem_write_enable = 1'b1;
            mem.mem_address      = ADDR_W'(TOTAL_ADDR);
            mem.mem_data_in      = total_sum;
            state_nxt            = S_FIN;
         end
         S_FIN: begin
            ready     = 1'b1;
            state_nxt = S_HALT;
         end
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sum_block_engine.sv
// ---------------------------------------------------------------------------
// tb_sum_block_engine
//   Directed bench for sum_block_engine with a behavioural 32x16 synchronous
//   RAM. Expected sums are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sum_block_engine;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ready;

   sum_block_engine_if #(.DATA_W(16), .ADDR_W(5)) bus ();

   sum_block_engine dut (
      .clk   (clk),
      .reset (reset),
      .ready (ready),
      .mem   (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural RAM; preload requests are serviced in the same process.
   logic [15:0] ram [32];
   logic [15:0] rd_q = '0;
   logic        rd_valid = 1'b0;
   logic        fill_req = 1'b0;
   logic        fill_ones = 1'b0;
   int          write_count = 0;

   always @(posedge clk) begin
      rd_valid <= bus.mem_read_enable;
      if (bus.mem_read_enable) rd_q <= ram[bus.mem_address];
      if (fill_req) begin
         for (int i = 0; i < 32; i++) ram[i] <= fill_ones ? 16'hFFFF : 16'(i);
      end else if (bus.mem_write_enable) begin
         ram[bus.mem_address] <= bus.mem_data_in;
         write_count <= write_count + 1;
      end
   end

   assign bus.mem_data_out = rd_valid ? rd_q : 'z;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit bus_idle();
      return !ready && !bus.mem_read_enable && !bus.mem_write_enable &&
             bus.mem_address == 5'd0 && bus.mem_data_in == 16'd0;
   endfunction

   task automatic fill(input bit ones);
      @(negedge clk);
      fill_ones = ones;
      fill_req  = 1'b1;
      @(negedge clk);
      fill_req  = 1'b0;
   endtask

   // Releases reset between edges; the next rising edge is edge 1.
   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_and_watch(output int rise_cyc, output int hi_len, output bit overlap);
      rise_cyc = -1;
      hi_len   = 0;
      overlap  = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.mem_read_enable && bus.mem_write_enable) overlap = 1'b1;
         if (ready) begin
            if (rise_cyc < 0) rise_cyc = cyc;
            hi_len++;
         end else if (rise_cyc >= 0) begin
            break;
         end
      end
   endtask

   task automatic check_run(input string tag);
      int rise_cyc, hi_len;
      bit overlap;
      run_and_watch(rise_cyc, hi_len, overlap);
      check({tag, "_ready_edge"}, rise_cyc, 47);
      check({tag, "_ready_len"}, hi_len, 1);
      check({tag, "_rw_overlap"}, 32'(overlap), 0);
   endtask

   logic [15:0] exp_ident [6] = '{16'd6, 16'd26, 16'd46, 16'd66, 16'd86, 16'd230};
   int          res_addr  [6] = '{4, 9, 14, 19, 24, 31};

   initial begin
      bit bad;

      // Reset state and a long reset hold with no RAM activity.
      #1;
      check("rst_ready", 32'(ready), 0);
      check("rst_rd_en", 32'(bus.mem_read_enable), 0);
      check("rst_wr_en", 32'(bus.mem_write_enable), 0);
      check("rst_addr", 32'(bus.mem_address), 0);
      check("rst_wdata", 32'(bus.mem_data_in), 0);
      fill(1'b0);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus_idle()) bad = 1'b1;
      end
      check("hold_idle", 32'(bad), 0);
      check("hold_no_writes", write_count, 0);

      // Identity-filled RAM.
      release_reset();
      check_run("ident");
      for (int g = 0; g < 6; g++) check($sformatf("ident_mem%0d", res_addr[g]), 32'(ram[res_addr[g]]), 32'(exp_ident[g]));
      for (int a = 25; a <= 30; a++) check($sformatf("ident_untouched%0d", a), 32'(ram[a]), a);
      bad = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (!bus_idle()) bad = 1'b1;
      end
      check("halt_idle", 32'(bad), 0);

      // All-ones RAM: group sums and total wrap.
      reset = 1'b0;
      fill(1'b1);
      release_reset();
      check_run("ones");
      for (int g = 0; g < 5; g++) check($sformatf("ones_mem%0d", res_addr[g]), 32'(ram[res_addr[g]]), 32'hFFFC);
      check("ones_total", 32'(ram[31]), 32'hFFEC);

      // Reset asserted during group 2, then a full rerun.
      reset = 1'b0;
      fill(1'b0);
      release_reset();
      repeat (20) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("abort_idle", 32'(bus_idle()), 1);
      check("abort_mem4", 32'(ram[4]), 6);
      check("abort_mem9", 32'(ram[9]), 26);
      check("abort_mem14", 32'(ram[14]), 14);
      repeat (3) @(posedge clk);
      release_reset();
      check_run("rerun");
      for (int g = 0; g < 6; g++) check($sformatf("rerun_mem%0d", res_addr[g]), 32'(ram[res_addr[g]]), 32'(exp_ident[g]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sum_block_engine.md
Name: sum_block_engine

Overview:
- Memory-mapped accumulator controller that drives an external 32x16 synchronous RAM.
- Reads five groups of four consecutive words and writes each group's sum to the word that follows the group.
- Writes the grand total of all group sums to address 31.
- Raises a one-cycle ready pulse when finished, then halts until the next reset.
- Sits between a system controller, which provides the clock and reset and watches ready, and a single-port RAM.

Parameters:
- DATA_W, 16, data word width; all arithmetic is modulo 2^DATA_W.
- ADDR_W, 5, memory address width.
- GROUP_LEN, 4, words summed per group (group stride = GROUP_LEN+1).
- NUM_GROUPS, 5, number of groups processed.
- TOTAL_ADDR, 31, address that receives the grand total.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately; high means run.
- ready  out  1  high for exactly one cycle after the final write.
- mem_address  out  ADDR_W  RAM address for the current read or write.
- mem_read_enable  out  1  read request. RAM registers memory[mem_address] onto mem_data_out at this rising edge.
- mem_write_enable  out  1  write strobe. RAM stores mem_data_in at mem_address on this rising edge.
- mem_data_in  out  DATA_W  write data to the RAM.
- mem_data_out  in  DATA_W  read data from the RAM. Valid in the cycle after a read request; may be Z otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; group sum, total, word index and group index are cleared.
  - Outputs: ready=0, both enables=0, mem_address=0, mem_data_in=0.
- Outputs are Moore: decoded from registered state and counters.
- mem_read_enable and mem_write_enable are never high in the same cycle.
- States and transitions:
  - IDLE: all outputs idle. Moves to RD_REQ on the first rising edge with reset=1.
  - RD_REQ: read_enable=1, address = 5*group + word. Next state RD_WAIT.
  - RD_WAIT: read_enable=0. At the closing edge, sum <= sum + mem_data_out. If word<3: word++, go to RD_REQ. Else go to WR_BLK.
  - WR_BLK: write_enable=1, address = 5*group + 4, data = sum. At the closing edge: total <= total + sum, sum <= 0, word <= 0. If group<4: group++, go to RD_REQ. Else go to WR_TOT.
  - WR_TOT: write_enable=1, address = TOTAL_ADDR, data = total. Next state FIN.
  - FIN: ready=1, enables=0. Next state HALT.
  - HALT: all outputs idle, ready=0. Remains here until reset is asserted.
- Latency:
  - 2 cycles per word read, 1 cycle per group write.
  - 45 cycles for the five groups, plus 1 cycle for WR_TOT.
  - FIN (ready high) is entered on the 47th rising edge after leaving IDLE.
- Address coverage:
  - Reads: 0-3, 5-8, 10-13, 15-18, 20-23.
  - Writes: 4, 9, 14, 19, 24, 31.
  - Addresses 25-30 are never accessed.
- Arithmetic: DATA_W-bit unsigned; overflow wraps silently with no saturation or flag.
- Reset mid-operation:
  - The current access is aborted immediately; outputs go idle.
  - On release, the sequence restarts from group 0 with cleared sums.
  - Writes already completed stay in memory.
- Each run starts at the first clock after reset release; there is no start input.

Test Plan:
- RAM preloaded memory[i]=i, reset low 40 ns then high, wait for ready rise then fall → mem[4]=6, mem[9]=26, mem[14]=46, mem[19]=66, mem[24]=86, mem[31]=230; mem[25..30] unchanged.
- Same run, monitor the bus:
  - ready is high for exactly 1 cycle, on the 47th edge after leaving IDLE.
  - read and write enables are never both high.
  - After FIN all outputs stay idle for 100+ cycles.
- RAM filled with 16'hFFFF → each group word = 16'hFFFC and mem[31] = 16'hFFEC (wrap-around).
- Assert reset low while the FSM is mid-way through group 2 (e.g. the 20th cycle after IDLE):
  - Outputs go idle immediately, with no edge needed.
  - After release, the run completes with correct values; the already-written group results are rewritten identically.
- Hold reset low for 50 cycles → ready=0, enables=0, address=0 throughout; no RAM writes occur.
